// File: rtl/cpu_pkg.sv
// Shared CPU constants and types used by the EX-stage multiply/divide unit.
package cpu_pkg;
  localparam int WIDTH         = 16;
  localparam int MULDIV_CYCLES = 16;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  typedef enum logic [1:0] {
    MD_IDLE,
    MD_CALC,
    MD_FIX,
    MD_DONE
  } muldiv_state_t;
endpackage

// File: rtl/ex_muldiv_if.sv
// Bundle between the EX-stage controller (master) and the multiply/divide unit (slave).
interface ex_muldiv_if;
  import cpu_pkg::*;

  // start/op/operands are sampled only while idle and ~flush; the request is then
  // owned by the unit until done pulses for one cycle with result_hi/result_lo/
  // div_by_zero valid; those results hold until the next accepted start.
  logic             start;
  logic             op;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic             flush;
  logic             busy;
  logic             stall_req;
  logic             done;
  logic [WIDTH-1:0] result_hi;
  logic [WIDTH-1:0] result_lo;
  logic             div_by_zero;

  modport master (
    output start, op, operand_a, operand_b, flush,
    input  busy, stall_req, done, result_hi, result_lo, div_by_zero
  );

  modport slave (
    input  start, op, operand_a, operand_b, flush,
    output busy, stall_req, done, result_hi, result_lo, div_by_zero
  );
endinterface

// File: rtl/muldiv_sign_fix.sv
// Conditional two's-complement negate; with neg = msb it yields the magnitude.
module muldiv_sign_fix #(
  parameter int W = 16
) (
  input  logic [W-1:0] val,
  input  logic         neg,
  output logic [W-1:0] res
);
  assign res = neg ? -val : val;
endmodule

// File: rtl/ex_muldiv.sv
// Multi-cycle signed MUL/DIV: magnitudes are iterated for 16 cycles, then sign-fixed.
module ex_muldiv
  import cpu_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  ex_muldiv_if.slave    bus,
  output muldiv_state_t state_dbg
);
  localparam logic [3:0] LAST_ITER = 4'(MULDIV_CYCLES - 1);
  localparam logic [3:0] MSB_IDX   = 4'(WIDTH - 1);

  muldiv_state_t      state;
  logic [3:0]         cnt;
  logic [WIDTH-1:0]   mag_a, mag_b, abs_a, abs_b;
  logic               op_q, res_sign, a_sign;
  logic [2*WIDTH-1:0] acc, addend, prod_fixed;
  logic [WIDTH-1:0]   rem, quo_fixed, rem_fixed, trial;
  logic [WIDTH:0]     rem_shift;
  logic               no_borrow;
  logic               done_q, dbz_q;
  logic [WIDTH-1:0]   res_hi, res_lo;
  logic               accept;

  assign accept        = (state == MD_IDLE) && bus.start && !bus.flush;
  assign bus.stall_req = accept || (state == MD_CALC) || (state == MD_FIX);
  assign bus.busy      = (state != MD_IDLE);
  assign bus.done      = done_q;
  assign bus.result_hi = res_hi;
  assign bus.result_lo = res_lo;
  assign bus.div_by_zero = dbz_q;
  assign state_dbg     = state;

  muldiv_sign_fix #(.W(WIDTH)) u_abs_a (.val(bus.operand_a), .neg(bus.operand_a[WIDTH-1]), .res(abs_a));
  muldiv_sign_fix #(.W(WIDTH)) u_abs_b (.val(bus.operand_b), .neg(bus.operand_b[WIDTH-1]), .res(abs_b));
  muldiv_sign_fix #(.W(2*WIDTH)) u_prod (.val(acc), .neg(res_sign), .res(prod_fixed));
  muldiv_sign_fix #(.W(WIDTH)) u_quo (.val(acc[WIDTH-1:0]), .neg(res_sign), .res(quo_fixed));
  muldiv_sign_fix #(.W(WIDTH)) u_rem (.val(rem), .neg(a_sign), .res(rem_fixed));

  // Shift-add term: multiplicand shifted to the weight of the current multiplier bit.
  assign addend = mag_b[cnt] ? ({{WIDTH{1'b0}}, mag_a} << cnt) : '0;

  // Restoring step: bring down the next dividend bit MSB-first into a 17-bit
  // partial remainder; a successful trial never exceeds 16 bits.
  assign rem_shift = {rem, mag_a[MSB_IDX - cnt]};
  assign no_borrow = (rem_shift >= {1'b0, mag_b});
  assign trial     = rem_shift[WIDTH-1:0] - mag_b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= MD_IDLE;
      cnt      <= '0;
      mag_a    <= '0;
      mag_b    <= '0;
      op_q     <= OP_MUL;
      res_sign <= 1'b0;
      a_sign   <= 1'b0;
      acc      <= '0;
      rem      <= '0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
      res_hi   <= '0;
      res_lo   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        MD_IDLE: begin
          if (accept) begin
            if (bus.op == OP_DIV && bus.operand_b == '0) begin
              state  <= MD_DONE;
              done_q <= 1'b1;
              res_hi <= bus.operand_a;
              res_lo <= '1;
              dbz_q  <= 1'b1;
            end else begin
              state    <= MD_CALC;
              mag_a    <= abs_a;
              mag_b    <= abs_b;
              op_q     <= bus.op;
              res_sign <= bus.operand_a[WIDTH-1] ^ bus.operand_b[WIDTH-1];
              a_sign   <= bus.operand_a[WIDTH-1];
              cnt      <= '0;
              acc      <= '0;
              rem      <= '0;
              dbz_q    <= 1'b0;
            end
          end
        end
        MD_CALC: begin
          if (bus.flush) begin
            state <= MD_IDLE;
          end else begin
            if (op_q == OP_MUL) begin
              acc <= acc + addend;
            end else begin
              rem <= no_borrow ? trial : rem_shift[WIDTH-1:0];
              acc <= {acc[2*WIDTH-2:0], no_borrow};
            end
            cnt <= cnt + 4'd1;
            if (cnt == LAST_ITER) state <= MD_FIX;
          end
        end
        MD_FIX: begin
          if (bus.flush) begin
            state <= MD_IDLE;
          end else begin
            if (op_q == OP_MUL) begin
              res_hi <= prod_fixed[2*WIDTH-1:WIDTH];
              res_lo <= prod_fixed[WIDTH-1:0];
            end else begin
              res_hi <= rem_fixed;
              res_lo <= quo_fixed;
            end
            done_q <= 1'b1;
            state  <= MD_DONE;
          end
        end
        default: state <= MD_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ex_muldiv.sv
// Bench for ex_muldiv: vector table plus random ops scored through an expected queue,
// and hand sequences for flush, reset, ignored start and flush/start collision.
module tb_ex_muldiv;
  import cpu_pkg::*;

  typedef struct {
    logic        op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] hi;
    logic [15:0] lo;
    logic        dbz;
  } vec_t;

  logic          clk;
  logic          rst;
  muldiv_state_t state_dbg;
  ex_muldiv_if   bus();

  int checks;
  int errors;
  int done_cnt;
  logic [32:0] exp_q[$];

  ex_muldiv dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // scoreboard: every done pops one expectation
  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        check("result_hi", 32'(bus.result_hi), 32'(e[31:16]));
        check("result_lo", 32'(bus.result_lo), 32'(e[15:0]));
        check("div_by_zero", 32'(bus.div_by_zero), 32'(e[32]));
      end
    end
  end

  task automatic drive_idle();
    bus.start = 1'b0; bus.op = OP_MUL; bus.operand_a = '0; bus.operand_b = '0; bus.flush = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_stall"}, 32'(bus.stall_req), 32'd0);
    check({tag, "_done"}, 32'(bus.done), 32'd0);
    check({tag, "_hi"}, 32'(bus.result_hi), 32'd0);
    check({tag, "_lo"}, 32'(bus.result_lo), 32'd0);
    check({tag, "_dbz"}, 32'(bus.div_by_zero), 32'd0);
    check({tag, "_state"}, 32'(state_dbg), 32'(MD_IDLE));
  endtask

  // Issue one op, score its result, and check latency and stall length.
  task automatic run_op(input logic op, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] eh, input logic [15:0] el, input logic ed);
    int lat, stl;
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.operand_a = a; bus.operand_b = b;
    #1 check("stall_on_start", 32'(bus.stall_req), 32'd1);
    exp_q.push_back({ed, eh, el});
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 0; stl = 0;
    while (bus.done !== 1'b1 && lat < 40) begin
      if (bus.stall_req === 1'b1) stl++;
      @(posedge clk); #1;
      lat++;
    end
    if (lat >= 40) begin
      check("done_timeout", 32'd1, 32'd0);
      void'(exp_q.pop_front());
    end else begin
      check("latency", 32'(lat), ed ? 32'd0 : 32'd17);
      check("stall_cycles", 32'(stl), ed ? 32'd0 : 32'd17);
      check("stall_in_done", 32'(bus.stall_req), 32'd0);
      @(posedge clk); #1;
      check("done_one_cycle", 32'(bus.done), 32'd0);
      check("idle_after_done", 32'(bus.busy), 32'd0);
    end
  endtask

  initial begin
    vec_t vecs[12];
    int   sa, sb, p;
    logic op;
    logic [15:0] a, b, eh, el;
    logic ed;
    int   d0;

    checks = 0; errors = 0; done_cnt = 0;
    vecs[0]  = '{OP_MUL, 16'h0007, 16'hFFFD, 16'hFFFF, 16'hFFEB, 1'b0};
    vecs[1]  = '{OP_MUL, 16'h7FFF, 16'h7FFF, 16'h3FFF, 16'h0001, 1'b0};
    vecs[2]  = '{OP_MUL, 16'h8000, 16'h8000, 16'h4000, 16'h0000, 1'b0};
    vecs[3]  = '{OP_MUL, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0001, 1'b0};
    vecs[4]  = '{OP_MUL, 16'h0100, 16'hFF00, 16'hFFFF, 16'h0000, 1'b0};
    vecs[5]  = '{OP_DIV, 16'hFFF9, 16'h0002, 16'hFFFF, 16'hFFFD, 1'b0};
    vecs[6]  = '{OP_DIV, 16'h8000, 16'hFFFF, 16'h0000, 16'h8000, 1'b0};
    vecs[7]  = '{OP_DIV, 16'h1234, 16'h0000, 16'h1234, 16'hFFFF, 1'b1};
    vecs[8]  = '{OP_DIV, 16'h0064, 16'h0007, 16'h0002, 16'h000E, 1'b0};
    vecs[9]  = '{OP_DIV, 16'h0007, 16'hFFFE, 16'h0001, 16'hFFFD, 1'b0};
    vecs[10] = '{OP_DIV, 16'h0005, 16'h000A, 16'h0005, 16'h0000, 1'b0};
    vecs[11] = '{OP_MUL, 16'h0000, 16'h8000, 16'h0000, 16'h0000, 1'b0};

    drive_idle();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 12; i++)
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, vecs[i].dbz);

    // random ops against plain signed arithmetic
    for (int i = 0; i < 8; i++) begin
      op = 1'($urandom_range(0, 1));
      a  = 16'($urandom_range(0, 65535));
      b  = 16'($urandom_range(0, 65535));
      sa = int'($signed(a));
      sb = int'($signed(b));
      ed = 1'b0;
      if (op == OP_MUL) begin
        p = sa * sb; eh = p[31:16]; el = p[15:0];
      end else if (b == 16'h0000) begin
        eh = a; el = 16'hFFFF; ed = 1'b1;
      end else begin
        p = sa / sb; el = p[15:0];
        p = sa % sb; eh = p[15:0];
      end
      run_op(op, a, b, eh, el, ed);
    end

    // flush at counter 8: abandoned, results keep the previous values
    run_op(OP_MUL, 16'h0007, 16'hFFFD, 16'hFFFF, 16'hFFEB, 1'b0);
    d0 = done_cnt;
    @(negedge clk);
    bus.start = 1'b1; bus.op = OP_MUL; bus.operand_a = 16'h1111; bus.operand_b = 16'h2222;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    check("flush_idle", 32'(bus.busy), 32'd0);
    repeat (25) @(posedge clk);
    #1;
    check("flush_no_done", 32'(done_cnt - d0), 32'd0);
    check("flush_keep_hi", 32'(bus.result_hi), 32'hFFFF);
    check("flush_keep_lo", 32'(bus.result_lo), 32'hFFEB);
    run_op(OP_MUL, 16'h0003, 16'h0004, 16'h0000, 16'h000C, 1'b0);

    // flush and start in the same idle cycle: not accepted
    @(negedge clk);
    bus.start = 1'b1; bus.flush = 1'b1; bus.op = OP_DIV; bus.operand_a = 16'h0009; bus.operand_b = 16'h0000;
    #1 check("flush_start_stall", 32'(bus.stall_req), 32'd0);
    @(posedge clk); #1;
    bus.start = 1'b0; bus.flush = 1'b0;
    check("flush_start_busy", 32'(bus.busy), 32'd0);
    check("flush_start_dbz", 32'(bus.div_by_zero), 32'd0);

    // start pulsed while busy is ignored
    d0 = done_cnt;
    @(negedge clk);
    bus.start = 1'b1; bus.op = OP_MUL; bus.operand_a = 16'h0005; bus.operand_b = 16'h0006;
    exp_q.push_back({1'b0, 16'h0000, 16'h001E});
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    bus.start = 1'b1; bus.op = OP_DIV; bus.operand_a = 16'h0001; bus.operand_b = 16'h0000;
    repeat (3) @(negedge clk);
    bus.start = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    check("busy_start_one_done", 32'(done_cnt - d0), 32'd1);

    // async reset mid-calc clears everything at once
    @(negedge clk);
    bus.start = 1'b1; bus.op = OP_MUL; bus.operand_a = 16'h0102; bus.operand_b = 16'h0304;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1 check_reset_outputs("mid_rst");
    @(negedge clk);
    rst = 1'b0;
    repeat (25) @(posedge clk);
    #1;
    check("post_rst_done_free", 32'(bus.busy), 32'd0);

    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
